// File: rtl/stopwatch_ctrl.sv
// 4-digit BCD stopwatch controller: run/pause/clear FSM, tick prescaler, digit scan.
// Optional lap/hold display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 100000,
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic        run,
    output logic [15:0] bcd,
    output logic        ovf,
    output logic [3:0]  digit_sel,
    output logic [3:0]  digit_val
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   presc;
    logic            tick;
    logic [3:0]      dig [4];
    logic [4:0]      inc;
    logic [15:0]     live;
    logic [15:0]     disp;
    logic [SW-1:0]   scnt;
    logic            scan_wrap;
    logic [1:0]      idx;
    logic [1:0]      idx_next;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else if (start_stop) begin
            case (state)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    assign run  = (state == RUN);
    assign tick = (state == RUN) && (presc == TW'(TICK_DIV - 1));

    // Prescaler freezes in PAUSE so a resumed run keeps its fractional tick.
    always_ff @(posedge clk) begin
        if (rst || clear) presc <= '0;
        else if (state == RUN) presc <= tick ? '0 : presc + 1'b1;
    end

    always_comb begin
        inc[0] = tick;
        for (int k = 0; k < 4; k++) begin
            inc[k+1] = inc[k] && (dig[k] == 4'd9);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int k = 0; k < 4; k++) dig[k] <= 4'd0;
            ovf <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (inc[k]) dig[k] <= (dig[k] == 4'd9) ? 4'd0 : dig[k] + 4'd1;
            end
            ovf <= inc[4];
        end
    end

    assign live = {dig[3], dig[2], dig[1], dig[0]};

`ifdef STOPWATCH_LAP_EN
    logic        hold;
    logic [15:0] lap_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hold  <= 1'b0;
            lap_q <= '0;
        end else if (lap && state != IDLE) begin
            hold <= ~hold;
            if (!hold) lap_q <= live;
        end
    end

    assign disp = hold ? lap_q : live;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign disp       = live;
`endif

    assign bcd = disp;

    assign scan_wrap = (scnt == SW'(SCAN_DIV - 1));
    assign idx_next  = scan_wrap ? idx + 2'd1 : idx;

    // Value is fetched with the next index so it lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt      <= '0;
            idx       <= 2'd0;
            digit_val <= 4'd0;
        end else begin
            scnt      <= scan_wrap ? '0 : scnt + 1'b1;
            idx       <= idx_next;
            digit_val <= disp[{idx_next, 2'b00} +: 4];
        end
    end

    assign digit_sel = ~(4'b0001 << idx);

endmodule
